// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier.
//   state_t            : FSM state encoding (IDLE=0, RUN=1, DONE=2), 2 bits.
//   MUL_WIDTH_DEFAULT  : default operand width.
package mul_pkg;

    localparam int MUL_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_left_wide.sv
// Combinational variable left shifter built as a chain of 2:1 muxes.
// Stage k shifts by 2**k when amt[k] is set; bits shifted out are dropped.
// Ports:
//   data_in  [DATA_W-1:0] : value to shift
//   amt      [AMT_W-1:0]  : shift amount
//   data_out [DATA_W-1:0] : data_in << amt
module shift_left_wide #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = 2
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] stage [AMT_W+1];

    assign stage[0] = data_in;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        assign stage[k+1] = amt[k] ? (stage[k] << (1 << k)) : stage[k];
    end

    assign data_out = stage[AMT_W];

endmodule

// File: rtl/shift_mul4.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE,
// and product is held stable there until out_ready is seen. Only one product
// is in flight; the next operand pair can be accepted the cycle after the
// product is taken.
//
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (a, b)
//   a, b     [WIDTH-1:0]  : unsigned operands
//   out_valid / out_ready : result handshake
//   product  [2*WIDTH-1:0]: a*b (last accumulator value outside DONE)
//   state_dbg [1:0]       : current FSM state, for observation
module shift_mul4
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         state_dbg
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [PW-1:0]    a_shifted;

    // Partial product candidate for the bit currently being processed.
    shift_left_wide #(
        .DATA_W (PW),
        .AMT_W  (CNT_W)
    ) u_shift (
        .data_in  ({{WIDTH{1'b0}}, a_q}),
        .amt      (cnt_q),
        .data_out (a_shifted)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Every bit is visited even when the upper bits of b are zero,
                // which keeps the latency independent of the operands.
                if (b_q[cnt_q]) begin
                    acc_d = acc_q + a_shifted;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from the registered state so reset reaches
    // them without waiting for a clock edge.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = acc_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_mul4.sv
module tb_shift_mul4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic [1:0] state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [7:0] exp_q[$];

    shift_mul4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Runs one multiplication starting in an IDLE cycle (called #1 after an edge).
    // hold     : cycles out_ready stays low once out_valid is seen
    // pulse_at : RUN cycle (1..4) in which a stray in_valid with 15*15 is driven, 0 = none
    task automatic do_mul(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] expv,
                          input int hold, input int pulse_at, input string tag);
        int lat;
        logic [7:0] got;
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        exp_q.push_back(expv);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        lat = 1;
        while (!out_valid && lat < 20) begin
            check({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
            if (lat == pulse_at) begin
                in_valid = 1'b1;
                a = 4'd15;
                b = 4'd15;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end
        check({tag, "_latency"}, lat, 32'd5);
        got = product;
        if (exp_q.size() > 0) check({tag, "_product"}, {24'd0, product}, {24'd0, exp_q.pop_front()});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_product"}, {24'd0, product}, {24'd0, got});
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_idle_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_state"}, {30'd0, state_dbg}, 32'd0);
    endtask

    initial begin
        int prev_cyc;
        int start_cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_product", {24'd0, product}, 32'd0);
        check("reset_state", {30'd0, state_dbg}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // basic and boundary vectors
        do_mul(4'd3,  4'd5,  8'h0F, 0, 0, "m3x5");
        do_mul(4'd15, 4'd15, 8'hE1, 0, 0, "m15x15");
        do_mul(4'd0,  4'd9,  8'h00, 0, 0, "m0x9");
        do_mul(4'd9,  4'd0,  8'h00, 0, 0, "m9x0");

        // consumer back-pressure
        do_mul(4'd7,  4'd6,  8'h2A, 3, 0, "m7x6_hold");

        // stray in_valid during RUN is ignored
        do_mul(4'd5,  4'd5,  8'h19, 0, 2, "m5x5_pulse");

        // asynchronous reset mid-RUN (cnt=2 is the third cycle after accept)
        in_valid = 1'b1; a = 4'd7; b = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_product", {24'd0, product}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_state", {30'd0, state_dbg}, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        do_mul(4'd2, 4'd3, 8'h06, 0, 0, "m2x3_after_rst");

        // back-to-back with out_ready tied high: one result every 6 cycles
        prev_cyc = -1;
        for (int i = 1; i <= 15; i++) begin
            start_cyc = cyc;
            if (prev_cyc >= 0) check("b2b_period", start_cyc - prev_cyc, 32'd6);
            prev_cyc = start_cyc;
            do_mul(4'(i), 4'(16 - i), 8'(i * (16 - i)), 0, 0, "b2b");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
